// File: rtl/fifo_pkg.sv
// fifo_pkg: constants shared by the FIFO write- and read-side controllers.
// Holds the default address width, depth derivation and pointer width.
package fifo_pkg;

    localparam int ADDR_WIDTH_DEF = 4;
    localparam int DEPTH_DEF      = 2 ** ADDR_WIDTH_DEF;
    localparam int PTR_W_DEF      = ADDR_WIDTH_DEF + 1;

    // Depth for a given address width.
    function automatic int depth_of(input int aw);
        return 2 ** aw;
    endfunction

    // Pointer width (address bits plus the lap bit).
    function automatic int ptr_w_of(input int aw);
        return aw + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: write-side pointer, level and flag generation for an async FIFO.
// Optional macro FIFO_WR_OVERFLOW_EN adds a sticky overflow output.
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int AFULL_TH   = depth_of(ADDR_WIDTH) - 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH:0]   rd_ptr_sync,
    output logic [ADDR_WIDTH:0]   wr_ptr,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wr_level,
`ifdef FIFO_WR_OVERFLOW_EN
    output logic                  overflow,
`endif
    output logic                  wr_ack
);

    localparam int PW = ptr_w_of(ADDR_WIDTH);
    localparam logic [PW-1:0] DEPTH_LVL = PW'(depth_of(ADDR_WIDTH));
    localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_TH);

    logic          accept;
    logic [PW-1:0] wr_ptr_next;
    logic [PW-1:0] level_next;
    logic          full_next;
    logic          afull_next;

    // Accept decision and next pointer/level/flag values.
    always_comb begin
        accept      = wr_en & ~full & ~rst;
        wr_ptr_next = wr_ptr + {{(PW-1){1'b0}}, accept};
        level_next  = wr_ptr_next - rd_ptr_sync;
        full_next   = (level_next == DEPTH_LVL);
        afull_next  = (level_next >= AFULL_LVL);
    end

    assign mem_we    = accept;
    assign mem_waddr = wr_ptr[ADDR_WIDTH-1:0];

    // Register pointer, level, flags and acknowledge.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            wr_level    <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wr_ack      <= 1'b0;
        end else begin
            wr_ptr      <= wr_ptr_next;
            wr_level    <= level_next;
            full        <= full_next;
            almost_full <= afull_next;
            wr_ack      <= accept;
        end
    end

`ifdef FIFO_WR_OVERFLOW_EN
    // Sticky record of any write attempted while full.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (wr_en && full) begin
            overflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb_fifo_wr_ctrl: directed self-checking bench for fifo_wr_ctrl.
// ADDR_WIDTH=4, DEPTH=16, AFULL_TH=14.
module tb_fifo_wr_ctrl;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [4:0] rd_ptr_sync;
    logic [4:0] wr_ptr;
    logic       mem_we;
    logic [3:0] mem_waddr;
    logic       full;
    logic       almost_full;
    logic [4:0] wr_level;
    logic       wr_ack;
`ifdef FIFO_WR_OVERFLOW_EN
    logic       overflow;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    fifo_wr_ctrl #(
        .ADDR_WIDTH (4),
        .AFULL_TH   (14)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .rd_ptr_sync (rd_ptr_sync),
        .wr_ptr      (wr_ptr),
        .mem_we      (mem_we),
        .mem_waddr   (mem_waddr),
        .full        (full),
        .almost_full (almost_full),
        .wr_level    (wr_level),
`ifdef FIFO_WR_OVERFLOW_EN
        .overflow    (overflow),
`endif
        .wr_ack      (wr_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        wr_en = 1'b0;
        rd_ptr_sync = 5'd0;
        tick();
        wr_en = 1'b1;
        #1;
        check("rst_mem_we", mem_we, 0);
        tick();
        check("rst_wr_ptr", wr_ptr, 0);
        check("rst_level", wr_level, 0);
        check("rst_full", full, 0);
        check("rst_afull", almost_full, 0);
        check("rst_ack", wr_ack, 0);

        // 16 back-to-back writes, read pointer parked at 0
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1;
            #1;
            check("fill_waddr", mem_waddr, i);
            check("fill_we", mem_we, 1);
            tick();
            check("fill_level", wr_level, i + 1);
            check("fill_afull", almost_full, (i + 1 >= 14) ? 1 : 0);
            check("fill_full", full, (i + 1 == 16) ? 1 : 0);
        end
        check("fill_ptr", wr_ptr, 16);
        check("fill_ack", wr_ack, 1);

        // writes while full are ignored
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1;
            #1;
            check("ovf_we", mem_we, 0);
            tick();
            check("ovf_ptr", wr_ptr, 16);
            check("ovf_ack", wr_ack, 0);
            check("ovf_full", full, 1);
`ifdef FIFO_WR_OVERFLOW_EN
            check("ovf_flag", overflow, 1);
`endif
        end

        // read side frees one slot
        wr_en = 1'b0;
        rd_ptr_sync = 5'd1;
        tick();
        check("drain_full", full, 0);
        check("drain_level", wr_level, 15);
`ifdef FIFO_WR_OVERFLOW_EN
        check("ovf_sticky", overflow, 1);
`endif
        wr_en = 1'b1;
        #1;
        check("refill_waddr", mem_waddr, 0);
        check("refill_we", mem_we, 1);
        tick();
        check("refill_ptr", wr_ptr, 17);
        check("refill_full", full, 1);
        check("refill_ack", wr_ack, 1);

        // level 8, write and read advance together
        wr_en = 1'b0;
        rd_ptr_sync = 5'd9;
        tick();
        check("l8_level", wr_level, 8);
        check("l8_full", full, 0);
        check("l8_afull", almost_full, 0);
        wr_en = 1'b1;
        rd_ptr_sync = 5'd10;
        tick();
        check("l8_same_level", wr_level, 8);
        check("l8_ack", wr_ack, 1);
        check("l8_ptr", wr_ptr, 18);

        // advance wr_ptr to 31, then set level 11 with rd=20
        rd_ptr_sync = 5'd18;
        for (int i = 0; i < 13; i++) tick();
        wr_en = 1'b0;
        rd_ptr_sync = 5'd20;
        tick();
        check("wrap_pre_ptr", wr_ptr, 31);
        check("wrap_pre_level", wr_level, 11);
        wr_en = 1'b1;
        tick();
        check("wrap_ptr", wr_ptr, 0);
        check("wrap_level", wr_level, 12);
        check("wrap_full", full, 0);

        // level 10, then reset mid-operation
        wr_en = 1'b0;
        rd_ptr_sync = 5'd22;
        tick();
        check("pre_rst_level", wr_level, 10);
        rst = 1'b1;
        wr_en = 1'b1;
        #1;
        check("mid_rst_we", mem_we, 0);
        tick();
        check("mid_rst_ptr", wr_ptr, 0);
        check("mid_rst_level", wr_level, 0);
        check("mid_rst_full", full, 0);
        check("mid_rst_afull", almost_full, 0);
`ifdef FIFO_WR_OVERFLOW_EN
        check("mid_rst_ovf", overflow, 0);
`endif
        rst = 1'b0;
        wr_en = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_wr_ctrl.md
FIFO_WR_CTRL -- requirements
Module: fifo_wr_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 4, the FIFO address width; depth DEPTH = 2**ADDR_WIDTH.
REQ-002 The block SHALL have parameter AFULL_TH, default DEPTH-2, the fill level at or above which almost_full asserts.
REQ-003 The block SHALL use a single clock; reset is synchronous and active-high.
REQ-004 clk  input  1  write-domain clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 wr_en  input  1  write request, one word per cycle.
REQ-007 rd_ptr_sync  input  ADDR_WIDTH+1  binary read pointer already resynchronised into clk (output of the gray-encoded synchroniser).
REQ-008 wr_ptr  output  ADDR_WIDTH+1  registered binary write pointer, fed to the gray-encoded synchroniser toward the read domain.
REQ-009 mem_we  output  1  memory write enable.
REQ-010 mem_waddr  output  ADDR_WIDTH  memory write address.
REQ-011 full  output  1  registered full flag.
REQ-012 almost_full  output  1  registered almost-full flag.
REQ-013 wr_level  output  ADDR_WIDTH+1  registered fill level as seen from the write side.
REQ-014 wr_ack  output  1  registered; high the cycle after a write was accepted.

Function
REQ-015 A write SHALL be accepted when wr_en=1 and full=0; mem_we = wr_en & ~full (combinational), mem_waddr = wr_ptr[ADDR_WIDTH-1:0].
REQ-016 On an accepted write, wr_ptr SHALL increment by 1 at the next clk edge, wrapping modulo 2**(ADDR_WIDTH+1) (MSB is the lap bit).
REQ-017 wr_en while full=1 SHALL be ignored: no mem_we, no pointer change, wr_ack=0.
REQ-018 Next level = (wr_ptr_next - rd_ptr_sync) mod 2**(ADDR_WIDTH+1), where wr_ptr_next includes the write accepted this cycle; wr_level, full and almost_full SHALL register from it.
REQ-019 full SHALL be 1 iff next level == DEPTH (MSBs differ, lower bits equal); almost_full iff next level >= AFULL_TH.
REQ-020 Writing the last free slot SHALL raise full the very next cycle, blocking a back-to-back write.
REQ-021 full SHALL deassert only after rd_ptr_sync advances; flags are pessimistic by the synchroniser latency, never optimistic.
REQ-022 A simultaneous accepted write and rd_ptr_sync advance SHALL leave the level unchanged.
REQ-023 rd_ptr_sync implying a level > DEPTH is illegal; behaviour is undefined and unchecked.

Reset
REQ-024 With rst=1 at a clk edge, wr_ptr, wr_level, full, almost_full and wr_ack SHALL be 0; mem_we SHALL be 0 while rst=1.
REQ-025 Reset mid-operation SHALL discard all pointer state immediately; the read side is reset concurrently by the parent.

Configuration
REQ-026 Macro FIFO_WR_OVERFLOW_EN: when defined, an extra output overflow (1 bit) SHALL set on any cycle with wr_en=1 and full=1 and stay set until rst; when undefined, the port and its logic SHALL be absent.

Structure
REQ-027 A shared package fifo_pkg SHALL hold the ADDR_WIDTH default, DEPTH derivation and pointer-width constant, common with the read-side controller.
REQ-028 No sub-module; pointer arithmetic inline; the gray-encoded synchroniser is instantiated by the parent FIFO, not inside this block.

Verification (ADDR_WIDTH=4, DEPTH=16, AFULL_TH=14)
REQ-029 rst, then 16 back-to-back wr_en with rd_ptr_sync=0 -> mem_waddr 0..15, wr_ptr ends 16 (5'b10000), full=1 the cycle after the 16th write, almost_full from level 14.
REQ-030 Full, wr_en held 3 more cycles -> no mem_we, wr_ptr stays 16, wr_ack=0; with FIFO_WR_OVERFLOW_EN overflow=1 and sticky.
REQ-031 Full, rd_ptr_sync 0->1 -> full=0 next cycle, wr_level=15; next write lands at mem_waddr 0, wr_ptr=17.
REQ-032 Level 8, wr_en=1 and rd_ptr_sync +1 same cycle -> wr_level stays 8, wr_ack=1.
REQ-033 Pointer wrap: drive wr_ptr from 31 with rd_ptr_sync=20 (level 11), one write -> wr_ptr=0, wr_level=12, full=0.
REQ-034 Assert rst at level 10 -> next cycle wr_ptr=0, wr_level=0, full=0, almost_full=0, overflow=0.
